// File: rtl/accumulator_bank.sv
// rtl/accumulator_bank.sv - one output-buffer bank: saturating accumulate, ordered drain-and-clear
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   bitwidth              mode; entry = buffer_row_write >> bitwidth
//   buffer_*_write        crossbar write strobe, row/column coordinate, signed product
//   drain_start           one-cycle request to drain the bank (honoured in IDLE only)
//   drain_ready           downstream accepts drain data
//   drain_valid/data/index  drain stream, entries presented in index order
//   drain_done            one-cycle pulse after the last entry transfers
//   bank_busy             high whenever not IDLE
//   write_dropped         sticky: a write was discarded (busy or out of range)

module accumulator_bank #(
    parameter int ENTRY_COUNT = 16,
    parameter int ENTRY_WIDTH = $clog2(ENTRY_COUNT),
    parameter int COORD_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             bitwidth,
    input  logic                   buffer_write_enable,
    input  logic [COORD_WIDTH-1:0] buffer_row_write,
    input  logic [COORD_WIDTH-1:0] buffer_column_write,
    input  logic [7:0]             buffer_data_write,
    input  logic                   drain_start,
    input  logic                   drain_ready,
    output logic                   drain_valid,
    output logic [7:0]             drain_data,
    output logic [ENTRY_WIDTH-1:0] drain_index,
    output logic                   drain_done,
    output logic                   bank_busy,
    output logic                   write_dropped
);

    localparam int unsigned ENTRY_COUNT_U = ENTRY_COUNT;
    localparam logic [ENTRY_WIDTH-1:0] LAST_INDEX = ENTRY_WIDTH'(ENTRY_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ENTRY_WIDTH-1:0]  drain_index_q, drain_index_d;
    logic                    write_dropped_q, write_dropped_d;
    logic                    s0_valid_q, s0_valid_d;
    logic [ENTRY_WIDTH-1:0]  s0_entry_q, s0_entry_d;
    logic [7:0]              s0_data_q, s0_data_d;
    logic [7:0]              mem_q [ENTRY_COUNT];
    logic [7:0]              mem_d [ENTRY_COUNT];

    logic [COORD_WIDTH-1:0]  shifted_row;
    logic                    in_range;
    logic                    accept;
    logic                    handshake;
    logic [7:0]              rmw_old;
    logic [8:0]              rmw_sum;
    logic [7:0]              rmw_sat;

    // Column coordinate only matters to the crossbar; nothing here addresses by it.
    logic unused_column;
    assign unused_column = ^buffer_column_write;

    assign shifted_row = buffer_row_write >> bitwidth;
    assign in_range    = 32'(shifted_row) < ENTRY_COUNT_U;
    // The drain_start cycle is still IDLE, so a write arriving with it is kept.
    assign accept      = buffer_write_enable && (state_q == S_IDLE) && in_range;
    assign handshake   = (state_q == S_DRAIN) && drain_ready;

    // Stage 1 read-modify-write. Each write commits to mem on the edge after it
    // leaves stage 0, so a following write to the same entry reads the updated
    // value directly and no forwarding path is needed.
    assign rmw_old = mem_q[s0_entry_q];
    assign rmw_sum = {rmw_old[7], rmw_old} + {s0_data_q[7], s0_data_q};

    always_comb begin
        rmw_sat = rmw_sum[7:0];
        // Sign bit and bit 7 disagree only on overflow of the 9-bit sum.
        if (rmw_sum[8:7] == 2'b01) begin
            rmw_sat = 8'h7f;
        end else if (rmw_sum[8:7] == 2'b10) begin
            rmw_sat = 8'h80;
        end
    end

    always_comb begin
        s0_valid_d = accept;
        s0_entry_d = shifted_row[ENTRY_WIDTH-1:0];
        s0_data_d  = buffer_data_write;

        write_dropped_d = write_dropped_q;
        if (buffer_write_enable && !accept) begin
            write_dropped_d = 1'b1;
        end

        mem_d = mem_q;
        if (s0_valid_q) begin
            mem_d[s0_entry_q] = rmw_sat;
        end
        if (handshake) begin
            mem_d[drain_index_q] = 8'h00;
        end

        state_d       = state_q;
        drain_index_d = drain_index_q;
        case (state_q)
            S_IDLE: begin
                if (drain_start) begin
                    state_d = S_FLUSH;
                end
            end
            // One cycle lets the write taken with drain_start retire before entry 0 is shown.
            S_FLUSH: begin
                drain_index_d = '0;
                state_d       = S_DRAIN;
            end
            S_DRAIN: begin
                if (handshake) begin
                    if (drain_index_q == LAST_INDEX) begin
                        state_d = S_DONE;
                    end else begin
                        drain_index_d = drain_index_q + ENTRY_WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                drain_index_d = '0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            drain_index_q   <= '0;
            write_dropped_q <= 1'b0;
            s0_valid_q      <= 1'b0;
            s0_entry_q      <= '0;
            s0_data_q       <= 8'h00;
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q         <= state_d;
            drain_index_q   <= drain_index_d;
            write_dropped_q <= write_dropped_d;
            s0_valid_q      <= s0_valid_d;
            s0_entry_q      <= s0_entry_d;
            s0_data_q       <= s0_data_d;
            mem_q           <= mem_d;
        end
    end

    assign drain_valid   = (state_q == S_DRAIN);
    assign drain_done    = (state_q == S_DONE);
    assign bank_busy     = (state_q != S_IDLE);
    assign drain_index   = drain_index_q;
    assign drain_data    = mem_q[drain_index_q];
    assign write_dropped = write_dropped_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// tb/tb_accumulator_bank.sv - self-checking bench for accumulator_bank

module tb_accumulator_bank;

    localparam int N = 16;
    localparam int P_IDLE  = 0;
    localparam int P_FLUSH = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] bitwidth = 2'd2;
    logic       buffer_write_enable = 1'b0;
    logic [7:0] buffer_row_write = 8'd0;
    logic [7:0] buffer_column_write = 8'd0;
    logic [7:0] buffer_data_write = 8'd0;
    logic       drain_start = 1'b0;
    logic       drain_ready = 1'b0;
    logic       drain_valid;
    logic [7:0] drain_data;
    logic [3:0] drain_index;
    logic       drain_done;
    logic       bank_busy;
    logic       write_dropped;

    accumulator_bank dut (
        .clk                 (clk),
        .reset               (reset),
        .bitwidth            (bitwidth),
        .buffer_write_enable (buffer_write_enable),
        .buffer_row_write    (buffer_row_write),
        .buffer_column_write (buffer_column_write),
        .buffer_data_write   (buffer_data_write),
        .drain_start         (drain_start),
        .drain_ready         (drain_ready),
        .drain_valid         (drain_valid),
        .drain_data          (drain_data),
        .drain_index         (drain_index),
        .drain_done          (drain_done),
        .bank_busy           (bank_busy),
        .write_dropped       (write_dropped)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Behavioural model of the bank
    int m_mem [N];
    int m_phase = P_IDLE;
    int m_idx = 0;
    int m_dropped = 0;

    // Observations of the drain stream
    int got_data[$];
    int got_index[$];
    int done_cnt = 0;
    int busy_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) m_mem[i] = 0;
            m_phase = P_IDLE;
            m_idx = 0;
            m_dropped = 0;
        end else begin
            if (buffer_write_enable) begin
                int e;
                e = int'(buffer_row_write) >> bitwidth;
                if (m_phase == P_IDLE && e < N)
                    m_mem[e] = sat8(m_mem[e] + int'($signed(buffer_data_write)));
                else
                    m_dropped = 1;
            end
            case (m_phase)
                P_IDLE:  if (drain_start) m_phase = P_FLUSH;
                P_FLUSH: begin m_phase = P_DRAIN; m_idx = 0; end
                P_DRAIN: if (drain_ready) begin
                    m_mem[m_idx] = 0;
                    if (m_idx == N - 1) m_phase = P_DONE;
                    else m_idx++;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("write_dropped", int'(write_dropped), m_dropped);
            case (m_phase)
                P_IDLE: begin
                    check("idle_valid", int'(drain_valid), 0);
                    check("idle_done", int'(drain_done), 0);
                    check("idle_busy", int'(bank_busy), 0);
                end
                P_FLUSH: begin
                    check("flush_valid", int'(drain_valid), 0);
                    check("flush_busy", int'(bank_busy), 1);
                end
                P_DRAIN: begin
                    check("drain_valid", int'(drain_valid), 1);
                    check("drain_index", int'(drain_index), m_idx);
                    check("drain_data", int'($signed(drain_data)), m_mem[m_idx]);
                    check("drain_busy", int'(bank_busy), 1);
                    check("drain_nodone", int'(drain_done), 0);
                end
                default: begin
                    check("done_pulse", int'(drain_done), 1);
                    check("done_valid", int'(drain_valid), 0);
                    check("done_busy", int'(bank_busy), 1);
                end
            endcase
            if (drain_valid && drain_ready) begin
                got_data.push_back(int'($signed(drain_data)));
                got_index.push_back(int'(drain_index));
            end
            if (drain_done) done_cnt++;
            if (bank_busy) busy_cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int row, input int data);
        buffer_write_enable = 1'b1;
        buffer_row_write    = row[7:0];
        buffer_column_write = 8'($urandom_range(0, 255));
        buffer_data_write   = data[7:0];
        step();
        buffer_write_enable = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
    // inject_cyc >= 0 drives a write to row 0 at that drain cycle.
    // reset_idx >= 0 asserts reset when entry reset_idx is being presented.
    task automatic do_drain(input int mode, input int inject_cyc, input int reset_idx,
                            input int sw_en, input int sw_row, input int sw_data);
        int done0;
        int k;
        bit finished;
        got_data.delete();
        got_index.delete();
        busy_cyc = 0;
        done0 = done_cnt;
        finished = 0;
        drain_start = 1'b1;
        if (sw_en != 0) begin
            buffer_write_enable = 1'b1;
            buffer_row_write    = sw_row[7:0];
            buffer_data_write   = sw_data[7:0];
        end
        step();
        drain_start = 1'b0;
        buffer_write_enable = 1'b0;
        for (k = 0; k < 200 && !finished; k++) begin
            drain_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            if (reset_idx >= 0 && m_phase == P_DRAIN && m_idx == reset_idx) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                check("rst_valid", int'(drain_valid), 0);
                check("rst_busy", int'(bank_busy), 0);
                check("rst_index", int'(drain_index), 0);
                check("rst_data", int'(drain_data), 0);
                finished = 1;
            end else begin
                if (k == inject_cyc) begin
                    buffer_write_enable = 1'b1;
                    buffer_row_write    = 8'd0;
                    buffer_data_write   = 8'd50;
                end
                step();
                buffer_write_enable = 1'b0;
                if (m_phase == P_IDLE) finished = 1;
            end
        end
        drain_ready = 1'b0;
        if (!finished) check("drain_timeout", k, -1);
        if (reset_idx < 0) begin
            @(negedge clk);
            check("done_count", done_cnt - done0, 1);
        end
    endtask

    task automatic check_all_zero(input string name);
        int nz;
        nz = 0;
        foreach (got_data[i]) if (got_data[i] != 0) nz++;
        check({name, "_len"}, got_data.size(), N);
        check({name, "_nonzero"}, nz, 0);
    endtask

    initial begin
        int done0;
        int bad_order;

        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("rst_drain_valid", int'(drain_valid), 0);
        check("rst_drain_data", int'(drain_data), 0);
        check("rst_drain_index", int'(drain_index), 0);
        check("rst_drain_done", int'(drain_done), 0);
        check("rst_bank_busy", int'(bank_busy), 0);
        check("rst_write_dropped", int'(write_dropped), 0);
        step();

        // Empty drain: 16 zeros, FLUSH + 16 DRAIN + DONE = 18 busy cycles
        do_drain(0, -1, -1, 0, 0, 0);
        check_all_zero("empty");
        check("busy_cycles", busy_cyc, 18);

        // Back-to-back writes to one entry: row 9 >> 2 = entry 2
        bitwidth = 2'd2;
        wr(9, 10);
        wr(9, 20);
        wr(9, -5);
        check("model_e2", m_mem[2], 25);
        do_drain(0, -1, -1, 0, 0, 0);
        check("b2b_len", got_data.size(), N);
        if (got_data.size() == N) begin
            check("b2b_e2", got_data[2], 25);
            check("b2b_e0", got_data[0], 0);
            check("b2b_e3", got_data[3], 0);
        end
        do_drain(0, -1, -1, 0, 0, 0);
        check_all_zero("second");

        // Saturation both ways
        wr(0, 100);
        wr(0, 100);
        wr(4, -100);
        wr(4, -100);
        check("model_sat_pos", m_mem[0], 127);
        check("model_sat_neg", m_mem[1], -128);
        // Write sharing the drain_start cycle lands in entry 15 (row 60)
        do_drain(0, -1, -1, 1, 60, -3);
        if (got_data.size() == N) begin
            check("sat_pos", got_data[0], 127);
            check("sat_neg", got_data[1], -128);
            check("start_cycle_write", got_data[15], -3);
        end else check("sat_len", got_data.size(), N);

        // Stalled drain: ready 1,0,0,1
        wr(12, 7);
        wr(63, 9);
        do_drain(1, -1, -1, 0, 0, 0);
        bad_order = 0;
        foreach (got_index[i]) if (got_index[i] != i) bad_order++;
        check("stall_len", got_index.size(), N);
        check("stall_order", bad_order, 0);
        if (got_data.size() == N) begin
            check("stall_e3", got_data[3], 7);
            check("stall_e15", got_data[15], 9);
        end
        check("stall_busy_gt", int'(busy_cyc > 18), 1);

        // Out-of-range row and a write during DRAIN are both discarded
        wr(64, 11);
        check("oor_dropped", int'(write_dropped), 1);
        wr(4, 9);
        do_drain(0, 5, -1, 0, 0, 0);
        if (got_data.size() == N) begin
            check("keep_e1", got_data[1], 9);
            check("keep_e0", got_data[0], 0);
        end else check("drop_len", got_data.size(), N);
        check("drop_sticky", int'(write_dropped), 1);
        do_drain(0, -1, -1, 0, 0, 0);
        check_all_zero("after_drop");

        // Reset in the middle of a drain
        wr(40, 33);
        done0 = done_cnt;
        do_drain(0, -1, 7, 0, 0, 0);
        repeat (3) step();
        check("rst_no_done", done_cnt - done0, 0);
        check("rst_clears_dropped", int'(write_dropped), 0);
        do_drain(0, -1, -1, 0, 0, 0);
        check_all_zero("post_reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
